cmdspi_burst: RTL
=================

CMDSPI_BURST -- requirements
Module: cmdspi_burst

Interface
REQ-001 SHALL provide parameter AW, default 7, address width in bits (1..15).
REQ-002 SHALL provide parameter DW, default 32, data width in bits (8..64, multiple of 8).
REQ-003 SHALL provide parameter SAMPLE_EDGE, default 0; 0 = sample/shift on SCLK falling, 1 = on SCLK rising.
REQ-004 SHALL provide parameter RD_LAT, default 1, clk cycles from re to rdat valid (1..3).
REQ-005 clk  input  1  main clock; one clock, reset is synchronous and active-high.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 CSN  input  1  async SPI chip select, active low.
REQ-008 SCLK  input  1  async SPI clock.
REQ-009 MOSI  input  1  async SPI data, master to slave.
REQ-010 MISO  output  1  SPI data, slave to master.
REQ-011 we  output  1  one-cycle write strobe.
REQ-012 re  output  1  one-cycle read request strobe.
REQ-013 addr  output  AW  current word address.
REQ-014 wdat  output  DW  write data, valid while we high.
REQ-015 rdat  input  DW  read data, valid RD_LAT cycles after re.
REQ-016 abort  output  1  one-cycle pulse when a frame ends mid-word.

Function
REQ-017 CSN, SCLK, MOSI SHALL pass through a 2-flop synchronizer plus one edge-detect flop; all decisions use synchronized values.
REQ-018 Frame format, MSB first: 1b R/W (1 = read), AW address bits, then DW-bit data words.
REQ-019 FSM states IDLE, CMD, ADDR, DATA, HOLD; CSN falling -> CMD from any state; CSN rising -> IDLE from any state.
REQ-020 CMD -> ADDR after 1 sampled bit; ADDR -> DATA after AW bits, latching addr; DATA counts DW bits per word.
REQ-021 Write: on the DW-th bit of a word, wdat SHALL load the full word and we SHALL pulse exactly one cycle later; addr and wdat stable while we high.
REQ-022 Read: re SHALL pulse the cycle after addr latches; rdat SHALL be captured into the tx shifter exactly RD_LAT cycles after re.
REQ-023 MISO SHALL equal tx shifter MSB; shifter shifts on each active edge in DATA; MISO = 0 in IDLE, CMD and ADDR.
REQ-024 SCLK half-period SHALL be >= RD_LAT+6 clk cycles; faster SCLK is unsupported, behaviour undefined.
REQ-025 CSN rising with 0 < bit count < DW in DATA SHALL pulse abort one cycle, discard the partial word, and produce no we.
REQ-026 CSN rising in CMD or ADDR SHALL pulse abort and leave addr unchanged.
REQ-027 SCLK edges while CSN high SHALL be ignored.

Reset
REQ-028 rst SHALL force IDLE; we, re, abort, MISO = 0; addr = 0; wdat = 0; shifters and counters cleared.
REQ-029 rst mid-frame SHALL discard the frame; bits are ignored until the next CSN falling edge.

Configuration
REQ-030 With CMDSPI_BURST_EN defined: after each complete word in DATA, addr increments by 1 modulo 2^AW (wrap 2^AW-1 -> 0); writes emit one we per word; reads pulse re for the new addr in the cycle after the increment.
REQ-031 Without CMDSPI_BURST_EN: after the first word the FSM enters HOLD, ignoring SCLK, MISO = 0, until CSN rises.

Structure
REQ-032 Package cmdspi_pkg SHALL hold the FSM state enumeration and default AW/DW/RD_LAT constants.
REQ-033 Synchronizer and edge detect SHALL be sub-module cmdspi_sync (3 bits in, sync values plus sclk_edge/csn_fall/csn_rise out).

Verification
REQ-034 Write 0x15, data 0xDEADBEEF -> one we, addr=0x15, wdat=0xDEADBEEF; no re.
REQ-035 Read 0x22 with rdat=0xCAFEF00D, RD_LAT=3 -> one re with addr=0x22; MISO shifts 0xCAFEF00D MSB first.
REQ-036 Burst write (macro on) from 0x7F, words 0x1, 0x2 -> we at addr 0x7F then 0x00 (wrap).
REQ-037 Same burst, macro off -> single we at 0x7F; second word ignored; MISO 0.
REQ-038 CSN rises after 17 data bits -> abort pulse, no we, wdat unchanged.
REQ-039 rst asserted during ADDR, then new write 0x05/0x0000FFFF -> no strobe from the aborted frame; one we, addr=0x05, wdat=0x0000FFFF.

Source files
------------

// File: rtl/cmdspi_pkg.sv
// Shared state encoding and default sizing for the command/address/data SPI slave.
package cmdspi_pkg;
  localparam int DEF_AW     = 7;
  localparam int DEF_DW     = 32;
  localparam int DEF_RD_LAT = 1;
  localparam int BIT_CNT_W  = 7;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, HOLD} cmdspi_state_e;
endpackage

// File: rtl/cmdspi_sync.sv
// Brings CSN/SCLK/MOSI into clk via two flops, then one history flop for edge detection.
// Latency: two clk cycles to sync values, edge strobes one cycle wide.
module cmdspi_sync #(
  parameter int SAMPLE_EDGE = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic csn_i,
  input  logic sclk_i,
  input  logic mosi_i,
  output logic csn_s,
  output logic mosi_s,
  output logic sclk_edge,
  output logic csn_fall,
  output logic csn_rise
);
  logic [2:0] meta_q, meta_d;
  logic [2:0] sync_q, sync_d;
  logic [1:0] prev_q, prev_d;

  always_comb begin
    meta_d = {csn_i, sclk_i, mosi_i};
    sync_d = meta_q;
    prev_d = sync_q[2:1];
  end

  // Cleared to zero so a reset taken with CSN low produces no false falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign csn_s     = sync_q[2];
  assign mosi_s    = sync_q[0];
  assign csn_fall  = prev_q[1] & ~sync_q[2];
  assign csn_rise  = ~prev_q[1] & sync_q[2];
  assign sclk_edge = (SAMPLE_EDGE != 0) ? (~prev_q[0] & sync_q[1]) : (prev_q[0] & ~sync_q[1]);
endmodule

// File: rtl/cmdspi_burst.sv
// SPI slave: R/W bit, address, then data words onto a strobe bus (we/re, rdat after RD_LAT).
// CMDSPI_BURST_EN: auto-increment addr per word; otherwise one word per frame, then HOLD.
module cmdspi_burst
  import cmdspi_pkg::*;
#(
  parameter int AW          = DEF_AW,
  parameter int DW          = DEF_DW,
  parameter int SAMPLE_EDGE = 0,
  parameter int RD_LAT      = DEF_RD_LAT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          CSN,
  input  logic          SCLK,
  input  logic          MOSI,
  output logic          MISO,
  output logic          we,
  output logic          re,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] wdat,
  input  logic [DW-1:0] rdat,
  output logic          abort
);
  logic csn_s, mosi_s, sclk_edge, csn_fall, csn_rise;

  cmdspi_sync #(.SAMPLE_EDGE(SAMPLE_EDGE)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .csn_i     (CSN),
    .sclk_i    (SCLK),
    .mosi_i    (MOSI),
    .csn_s     (csn_s),
    .mosi_s    (mosi_s),
    .sclk_edge (sclk_edge),
    .csn_fall  (csn_fall),
    .csn_rise  (csn_rise)
  );

  cmdspi_state_e        state_q, state_d;
  logic                 rw_q, rw_d;
  logic [BIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]        ash_q, ash_d;
  logic [DW-1:0]        rsh_q, rsh_d;
  logic [DW-1:0]        tx_q, tx_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [DW-1:0]        wdat_q, wdat_d;
  logic                 wpend_q, wpend_d;
  logic                 we_q, we_d;
  logic                 re_req_q, re_req_d;
  logic                 re_q, re_d;
  logic                 abort_q, abort_d;
  logic [1:0]           rd_cnt_q, rd_cnt_d;
  logic                 miso_q, miso_d;

  always_comb begin
    state_d  = state_q;
    rw_d     = rw_q;
    cnt_d    = cnt_q;
    ash_d    = ash_q;
    rsh_d    = rsh_q;
    tx_d     = tx_q;
    addr_d   = addr_q;
    wdat_d   = wdat_q;
    wpend_d  = 1'b0;
    we_d     = wpend_q;
    re_req_d = 1'b0;
    re_d     = re_req_q;
    abort_d  = 1'b0;
    rd_cnt_d = (rd_cnt_q != 2'd0) ? rd_cnt_q - 2'd1 : 2'd0;
    if (re_q) rd_cnt_d = 2'(RD_LAT);
`ifdef CMDSPI_BURST_EN
    // Write bursts step the address after the strobe so addr holds steady under we.
    if (we_q) addr_d = addr_q + AW'(1);
`endif
    if (csn_rise) begin
      abort_d = (state_q == CMD) || (state_q == ADDR) || ((state_q == DATA) && (cnt_q != '0));
      state_d = IDLE;
      cnt_d   = '0;
    end else if (csn_fall) begin
      state_d = CMD;
      cnt_d   = '0;
      rsh_d   = '0;
      tx_d    = '0;
    end else if (sclk_edge && !csn_s) begin
      case (state_q)
        CMD: begin
          rw_d    = mosi_s;
          state_d = ADDR;
        end
        ADDR: begin
          ash_d = (ash_q << 1) | AW'(mosi_s);
          if (cnt_q == BIT_CNT_W'(AW - 1)) begin
            addr_d   = ash_d;
            state_d  = DATA;
            cnt_d    = '0;
            re_req_d = rw_q;
          end else begin
            cnt_d = cnt_q + BIT_CNT_W'(1);
          end
        end
        DATA: begin
          rsh_d = {rsh_q[DW-2:0], mosi_s};
          tx_d  = {tx_q[DW-2:0], 1'b0};
          if (cnt_q == BIT_CNT_W'(DW - 1)) begin
            cnt_d = '0;
            if (!rw_q) begin
              wdat_d  = rsh_d;
              wpend_d = 1'b1;
            end
`ifdef CMDSPI_BURST_EN
            // Reads step immediately so the next word is fetched before the master samples it.
            if (rw_q) begin
              addr_d   = addr_q + AW'(1);
              re_req_d = 1'b1;
            end
`else
            state_d = HOLD;
`endif
          end else begin
            cnt_d = cnt_q + BIT_CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
    if (rd_cnt_q == 2'd1) tx_d = rdat;
    miso_d = (state_d == DATA) ? tx_d[DW-1] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rw_q     <= 1'b0;
      cnt_q    <= '0;
      ash_q    <= '0;
      rsh_q    <= '0;
      tx_q     <= '0;
      addr_q   <= '0;
      wdat_q   <= '0;
      wpend_q  <= 1'b0;
      we_q     <= 1'b0;
      re_req_q <= 1'b0;
      re_q     <= 1'b0;
      abort_q  <= 1'b0;
      rd_cnt_q <= 2'd0;
      miso_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rw_q     <= rw_d;
      cnt_q    <= cnt_d;
      ash_q    <= ash_d;
      rsh_q    <= rsh_d;
      tx_q     <= tx_d;
      addr_q   <= addr_d;
      wdat_q   <= wdat_d;
      wpend_q  <= wpend_d;
      we_q     <= we_d;
      re_req_q <= re_req_d;
      re_q     <= re_d;
      abort_q  <= abort_d;
      rd_cnt_q <= rd_cnt_d;
      miso_q   <= miso_d;
    end
  end

  assign MISO  = miso_q;
  assign we    = we_q;
  assign re    = re_q;
  assign addr  = addr_q;
  assign wdat  = wdat_q;
  assign abort = abort_q;
endmodule
